// File: rtl/multi_clk_divider_if.sv
// Configuration port bundle for multi_clk_divider.
// Ports: cfg_valid/cfg_ready handshake, cfg_chan/cfg_en/cfg_div/cfg_phase
//        request fields, cfg_err one-cycle reject pulse.
interface multi_clk_divider_if #(
    parameter int CHAN_W = 3,
    parameter int DIV_W  = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic              cfg_en;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_err;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_en,
        output cfg_div,
        output cfg_phase,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_en,
        input  cfg_div,
        input  cfg_phase,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/multi_clk_divider.sv
// Multi-channel integer clock divider with glitch-free reconfiguration
// and a configuration-stable lock flag.
// Ports: refclk (sole clock), rst (async, active-low), cfg (config
//        handshake bundle, slave side), outclk / outclk_tick (per-channel
//        divided clock and period-start pulse), locked.
module multi_clk_divider #(
    parameter int                    NUM_CLOCKS  = 4,
    parameter int                    DIV_W       = 16,
    parameter int                    DEFAULT_DIV = 10,
    parameter logic [NUM_CLOCKS-1:0] RST_EN      = 'b1,
    parameter int                    LOCK_CYCLES = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    multi_clk_divider_if.slave    cfg,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_tick,
    output logic                  locked
);

    localparam int CW = $clog2(NUM_CLOCKS) + 1;
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
    localparam logic [LW-1:0]    LK_MAX  = LW'(LOCK_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Per-channel state. cnt doubles as the phase down-counter in PHASE
    // and the period counter in RUN.
    state_e           st_q  [NUM_CLOCKS];
    state_e           st_d  [NUM_CLOCKS];
    logic [DIV_W-1:0] div_q [NUM_CLOCKS];
    logic [DIV_W-1:0] div_d [NUM_CLOCKS];
    logic [DIV_W-1:0] cnt_q [NUM_CLOCKS];
    logic [DIV_W-1:0] cnt_d [NUM_CLOCKS];
    logic [DIV_W-1:0] nxt   [NUM_CLOCKS];
    logic [DIV_W-1:0] half  [NUM_CLOCKS];

    logic [NUM_CLOCKS-1:0] en_q, en_d;
    logic [NUM_CLOCKS-1:0] clk_q, clk_d;
    logic [NUM_CLOCKS-1:0] tick_q, tick_d;
    logic [NUM_CLOCKS-1:0] hit, wrap, app;

    // Single pending configuration slot; fields hold effective values.
    logic             pend_q, pend_d;
    logic [CW-1:0]    pch_q, pch_d;
    logic             pen_q, pen_d;
    logic [DIV_W-1:0] pdiv_q, pdiv_d;
    logic [DIV_W-1:0] pph_q, pph_d;

    logic             rdy_q, rdy_d;
    logic             err_q, err_d;
    logic [LW-1:0]    lk_q, lk_d;
    logic             lock_q, lock_d;

    logic [DIV_W-1:0] in_div, in_ph;
    logic             xfer, acc, any_app, any_en;

    // Ratios below 2 cannot toggle; phase is limited to one period.
    assign in_div = (cfg.cfg_div < DIV_MIN) ? DIV_MIN : cfg.cfg_div;
    assign in_ph  = (cfg.cfg_phase >= in_div) ? in_div - ONE
                                              : cfg.cfg_phase;

    assign xfer = cfg.cfg_valid & rdy_q;
    assign acc  = xfer & (cfg.cfg_chan < CW'(NUM_CLOCKS));

    for (genvar g = 0; g < NUM_CLOCKS; g++) begin : g_ch
        assign hit[g]  = pend_q && (pch_q == CW'(g));
        assign wrap[g] = (cnt_q[g] == div_q[g] - ONE);
        assign nxt[g]  = wrap[g] ? '0 : cnt_q[g] + ONE;
        // High for ceil(div/2) counts at the start of each period.
        assign half[g] = div_q[g] - (div_q[g] >> 1);
    end

    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            st_d[i]   = st_q[i];
            div_d[i]  = div_q[i];
            cnt_d[i]  = cnt_q[i];
            en_d[i]   = en_q[i];
            clk_d[i]  = 1'b0;
            tick_d[i] = 1'b0;
            app[i]    = 1'b0;
            unique case (st_q[i])
                IDLE: begin
                    if (hit[i]) begin
                        app[i]   = 1'b1;
                        en_d[i]  = pen_q;
                        div_d[i] = pdiv_q;
                        cnt_d[i] = pph_q;
                        st_d[i]  = pen_q ? PHASE : IDLE;
                    end
                end
                PHASE: begin
                    if (hit[i]) begin
                        app[i]   = 1'b1;
                        en_d[i]  = pen_q;
                        div_d[i] = pdiv_q;
                        cnt_d[i] = pph_q;
                        st_d[i]  = pen_q ? PHASE : IDLE;
                    end else if (cnt_q[i] == '0) begin
                        st_d[i]   = RUN;
                        clk_d[i]  = 1'b1;
                        tick_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - ONE;
                    end
                end
                RUN: begin
                    // A pending change waits for the period boundary so
                    // the current high/low phases always complete.
                    if (wrap[i] && hit[i]) begin
                        app[i]   = 1'b1;
                        en_d[i]  = pen_q;
                        div_d[i] = pdiv_q;
                        cnt_d[i] = '0;
                        if (pen_q) begin
                            clk_d[i]  = 1'b1;
                            tick_d[i] = 1'b1;
                        end else begin
                            st_d[i] = IDLE;
                        end
                    end else begin
                        cnt_d[i]  = nxt[i];
                        clk_d[i]  = (nxt[i] < half[i]);
                        tick_d[i] = wrap[i];
                    end
                end
                default: begin
                    st_d[i] = IDLE;
                end
            endcase
        end
    end

    assign any_app = |app;
    assign any_en  = |en_q;

    always_comb begin
        pend_d = pend_q;
        pch_d  = pch_q;
        pen_d  = pen_q;
        pdiv_d = pdiv_q;
        pph_d  = pph_q;
        if (any_app) begin
            pend_d = 1'b0;
        end
        if (acc) begin
            pend_d = 1'b1;
            pch_d  = cfg.cfg_chan;
            pen_d  = cfg.cfg_en;
            pdiv_d = in_div;
            pph_d  = in_ph;
        end
        // Ready stays low through the apply cycle, back one edge later.
        rdy_d = ~pend_q & ~pend_d;
        err_d = xfer & ~acc;
        if (acc || pend_d || !any_en) begin
            lk_d = '0;
        end else if (lk_q == LK_MAX) begin
            lk_d = lk_q;
        end else begin
            lk_d = lk_q + LW'(1);
        end
        lock_d = (lk_q == LK_MAX) & ~acc;
    end

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                st_q[i]  <= RST_EN[i] ? PHASE : IDLE;
                div_q[i] <= DIV_W'(DEFAULT_DIV);
                cnt_q[i] <= '0;
            end
            en_q   <= RST_EN;
            clk_q  <= '0;
            tick_q <= '0;
            pend_q <= 1'b0;
            pch_q  <= '0;
            pen_q  <= 1'b0;
            pdiv_q <= '0;
            pph_q  <= '0;
            rdy_q  <= 1'b1;
            err_q  <= 1'b0;
            lk_q   <= '0;
            lock_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                st_q[i]  <= st_d[i];
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            en_q   <= en_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
            pch_q  <= pch_d;
            pen_q  <= pen_d;
            pdiv_q <= pdiv_d;
            pph_q  <= pph_d;
            rdy_q  <= rdy_d;
            err_q  <= err_d;
            lk_q   <= lk_d;
            lock_q <= lock_d;
        end
    end

    assign outclk        = clk_q;
    assign outclk_tick   = tick_q;
    assign locked        = lock_q;
    assign cfg.cfg_ready = rdy_q;
    assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_multi_clk_divider.sv
// Self-checking bench for multi_clk_divider: directed vectors, corner
// sequences and random config traffic against a timeline reference model.
module tb_multi_clk_divider;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int CW   = 3;
    localparam int DEF  = 10;
    localparam int LOCK = 16;

    logic         refclk = 1'b0;
    logic         rst    = 1'b0;
    logic [N-1:0] outclk;
    logic [N-1:0] outclk_tick;
    logic         locked;

    multi_clk_divider_if #(.CHAN_W(CW), .DIV_W(DW)) cfg ();

    multi_clk_divider #(
        .NUM_CLOCKS (N),
        .DIV_W      (DW),
        .DEFAULT_DIV(DEF),
        .RST_EN     (4'b0001),
        .LOCK_CYCLES(LOCK)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .cfg        (cfg),
        .outclk     (outclk),
        .outclk_tick(outclk_tick),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a timeline. A running channel has a
    // period origin edge and a ratio; its output at edge e follows from
    // (e - origin) mod ratio. A waiting channel starts at a known edge.
    int mode [N];  // 0 off, 1 waiting, 2 running
    int wake [N];
    int org  [N];
    int dv   [N];
    int e;
    int last_dis;
    bit p_v, p_en, m_rdy;
    int p_ch, p_div, p_ph;
    bit [N-1:0] x_clk, x_tick;
    bit x_lock, x_err, x_rdy;

    function automatic int effdiv(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic int effph(input int p, input int d);
        return (p >= d) ? d - 1 : p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mode[i] = (i == 0) ? 1 : 0;
            wake[i] = 0;
            org[i]  = 0;
            dv[i]   = DEF;
        end
        e        = 0;
        last_dis = -1;
        p_v      = 0;
        m_rdy    = 1;
    endtask

    task automatic model_edge(input bit v, input int ch, input bit en,
                              input int d, input int ph);
        bit acc, rej, any_en, pend_before, hitc;
        int k;
        any_en = 0;
        for (int i = 0; i < N; i++) if (mode[i] != 0) any_en = 1;
        pend_before = p_v;
        acc = v && m_rdy && (ch < N);
        rej = v && m_rdy && (ch >= N);
        for (int i = 0; i < N; i++) begin
            x_clk[i]  = 0;
            x_tick[i] = 0;
            hitc = p_v && (p_ch == i);
            if (hitc && (mode[i] != 2 || ((e - org[i]) % dv[i]) == 0)) begin
                p_v = 0;
                if (!p_en) begin
                    mode[i] = 0;
                end else if (mode[i] == 2) begin
                    org[i] = e;
                    dv[i]  = p_div;
                end else begin
                    mode[i] = 1;
                    wake[i] = e + p_ph + 1;
                    dv[i]   = p_div;
                end
            end else if (mode[i] == 1 && e == wake[i]) begin
                mode[i] = 2;
                org[i]  = e;
            end
            if (mode[i] == 2) begin
                k = (e - org[i]) % dv[i];
                x_clk[i]  = (k < (dv[i] + 1) / 2);
                x_tick[i] = (k == 0);
            end
        end
        if (acc) begin
            p_v   = 1;
            p_ch  = ch;
            p_en  = en;
            p_div = effdiv(d);
            p_ph  = effph(ph, p_div);
        end
        x_rdy  = !pend_before && !p_v;
        m_rdy  = x_rdy;
        x_err  = rej;
        x_lock = !acc && ((e - 1 - last_dis) >= LOCK);
        if (acc || p_v || !any_en) last_dis = e;
        e++;
    endtask

    task automatic cycle();
        @(posedge refclk);
        model_edge(cfg.cfg_valid, int'(cfg.cfg_chan), cfg.cfg_en,
                   int'(cfg.cfg_div), int'(cfg.cfg_phase));
        #1;
        chk("m_outclk", int'(outclk), int'(x_clk));
        chk("m_tick", int'(outclk_tick), int'(x_tick));
        chk("m_locked", int'(locked), int'(x_lock));
        chk("m_ready", int'(cfg.cfg_ready), int'(x_rdy));
        chk("m_err", int'(cfg.cfg_err), int'(x_err));
    endtask

    task automatic send(input int ch, input bit en, input int d, input int ph);
        bit r, ok;
        cfg.cfg_valid = 1'b1;
        cfg.cfg_chan  = CW'(ch);
        cfg.cfg_en    = en;
        cfg.cfg_div   = DW'(d);
        cfg.cfg_phase = DW'(ph);
        ok = 0;
        for (int t = 0; t < 40 && !ok; t++) begin
            r = m_rdy;
            cycle();
            if (r) ok = 1;
        end
        cfg.cfg_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic measure(input int ch, output int hi, output int lo);
        int t;
        t  = 0;
        hi = 0;
        lo = 0;
        while (outclk[ch] && t < 60) begin cycle(); t++; end
        while (!outclk[ch] && t < 120) begin cycle(); t++; end
        while (outclk[ch] && t < 200) begin hi++; cycle(); t++; end
        while (!outclk[ch] && t < 300) begin lo++; cycle(); t++; end
    endtask

    typedef struct {
        int ch;
        bit en;
        int dv;
        int ph;
        bit xerr;
        int xhi;
        int xlo;
    } vec_t;

    vec_t vt [10];

    initial begin
        int hi, lo, cnt;
        bit exp_clk;

        vt[0] = '{1, 1, 6, 2, 0, 3, 3};
        vt[1] = '{2, 1, 7, 0, 0, 4, 3};
        vt[2] = '{3, 1, 0, 5, 0, 1, 1};
        vt[3] = '{3, 1, 1, 0, 0, 1, 1};
        vt[4] = '{0, 1, 4, 9, 0, 2, 2};
        vt[5] = '{2, 1, 5, 3, 0, 3, 2};
        vt[6] = '{7, 1, 3, 0, 1, 0, 0};
        vt[7] = '{4, 1, 3, 0, 1, 0, 0};
        vt[8] = '{1, 0, 6, 0, 0, 0, 0};
        vt[9] = '{0, 1, 3, 0, 0, 2, 1};

        cfg.cfg_valid = 1'b0;
        cfg.cfg_chan  = '0;
        cfg.cfg_en    = 1'b0;
        cfg.cfg_div   = '0;
        cfg.cfg_phase = '0;

        repeat (2) @(negedge refclk);
        chk("rst_outclk", int'(outclk), 0);
        chk("rst_tick", int'(outclk_tick), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_ready", int'(cfg.cfg_ready), 1);
        chk("rst_err", int'(cfg.cfg_err), 0);
        rst = 1'b1;
        model_reset();

        // Default channel 0 waveform and lock rise after release.
        for (int k = 0; k <= 22; k++) begin
            cycle();
            chk("t1_clk0", int'(outclk[0]), int'((k % 10) < 5));
            chk("t1_tick0", int'(outclk_tick[0]), int'((k % 10) == 0));
            chk("t1_idle", int'(outclk[3:1]), 0);
            chk("t2_lock", int'(locked), int'(k >= 16));
        end

        // Mid-period ratio change: transfer at edge 23, boundary at 30.
        cfg.cfg_valid = 1'b1;
        cfg.cfg_chan  = CW'(0);
        cfg.cfg_en    = 1'b1;
        cfg.cfg_div   = DW'(4);
        cfg.cfg_phase = '0;
        for (int k = 23; k <= 50; k++) begin
            cycle();
            if (k == 23) cfg.cfg_valid = 1'b0;
            exp_clk = (k < 30) ? ((k % 10) < 5) : (((k - 30) % 4) < 2);
            chk("t3_clk0", int'(outclk[0]), int'(exp_clk));
            chk("t3_ready", int'(cfg.cfg_ready), int'(!(k >= 23 && k <= 30)));
            chk("t3_lock", int'(locked), int'(k >= 46));
        end

        for (int v = 0; v < 10; v++) begin
            send(vt[v].ch, vt[v].en, vt[v].dv, vt[v].ph);
            chk("vec_err", int'(cfg.cfg_err), int'(vt[v].xerr));
            if (!vt[v].xerr) begin
                for (int t = 0; t < 60 && !cfg.cfg_ready; t++) cycle();
                chk("vec_ready", int'(cfg.cfg_ready), 1);
                if (vt[v].en) begin
                    measure(vt[v].ch, hi, lo);
                    chk("vec_hi", hi, vt[v].xhi);
                    chk("vec_lo", lo, vt[v].xlo);
                end else begin
                    cnt = 0;
                    repeat (20) begin
                        cycle();
                        cnt += int'(outclk[vt[v].ch]);
                    end
                    chk("vec_off", cnt, 0);
                end
            end
        end

        // Pending config dropped by a mid-operation reset.
        send(0, 1, 12, 0);
        chk("t6_pending", int'(cfg.cfg_ready), 0);
        rst = 1'b0;
        #1;
        chk("t6_outclk", int'(outclk), 0);
        chk("t6_tick", int'(outclk_tick), 0);
        chk("t6_locked", int'(locked), 0);
        chk("t6_ready", int'(cfg.cfg_ready), 1);
        repeat (2) @(negedge refclk);
        rst = 1'b1;
        model_reset();
        measure(0, hi, lo);
        chk("t6_hi", hi, 5);
        chk("t6_lo", lo, 5);

        repeat (400) begin
            cfg.cfg_valid = ($urandom_range(0, 3) == 0);
            cfg.cfg_chan  = CW'($urandom_range(0, 5));
            cfg.cfg_en    = ($urandom_range(0, 3) != 0);
            cfg.cfg_div   = DW'($urandom_range(0, 9));
            cfg.cfg_phase = DW'($urandom_range(0, 12));
            cycle();
        end
        cfg.cfg_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
